// File: rtl/reg_file_pkg.sv
// reg_file_pkg
// Shared defaults and index/word types for the scoreboarded register file.
// Contents:
//   DATA_W_DEF   - default register width
//   ADDR_W_DEF   - default register index width (depth = 2**ADDR_W_DEF)
//   ZERO_REG_DEF - default index of the hardwired-zero register
//   reg_idx_t    - register index type at the default width
//   reg_word_t   - register word type at the default width
package reg_file_pkg;

  localparam int DATA_W_DEF   = 64;
  localparam int ADDR_W_DEF   = 5;
  localparam int ZERO_REG_DEF = 31;

  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
  typedef logic [DATA_W_DEF-1:0] reg_word_t;

endpackage

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard
// Per-register pending bits plus a running count of pending registers.
// A register becomes pending when an instruction targeting it issues and
// stops being pending when writeback writes it. If both happen to the same
// register in one cycle the issue wins: the newer instruction owns it.
// Ports:
//   Clk      - clock, state updates on rising edge
//   ResetL   - synchronous active-low reset (clears pend and PendCnt)
//   IssueVal - an instruction with a destination issues this cycle
//   IssueRd  - destination register of the issuing instruction
//   RegWr    - writeback enable
//   RW       - writeback register index
//   pend     - pending bit per register (ZERO_REG bit is always 0)
//   PendCnt  - number of registers currently pending
// There is no handshake: every input is sampled on every rising edge.
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF
) (
  input  logic                  Clk,
  input  logic                  ResetL,
  input  logic                  IssueVal,
  input  logic [ADDR_W-1:0]     IssueRd,
  input  logic                  RegWr,
  input  logic [ADDR_W-1:0]     RW,
  output logic [2**ADDR_W-1:0]  pend,
  output logic [ADDR_W:0]       PendCnt
);

  localparam int                DEPTH    = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [DEPTH-1:0] pend_next;
  logic [ADDR_W:0]  cnt_next;
  logic             issue_ok;
  logic             set_new;
  logic             clr_real;

  assign issue_ok = IssueVal && (IssueRd != ZERO_IDX);

  // Count only real 0->1 and 1->0 transitions so re-issues and writes to
  // non-pending registers leave the count alone. A clear that loses to a
  // same-register issue is not a transition.
  assign set_new  = issue_ok && !pend[IssueRd];
  assign clr_real = RegWr && pend[RW] && !(issue_ok && (IssueRd == RW));

  always_comb begin
    pend_next = pend;
    if (RegWr) begin
      pend_next[RW] = 1'b0;
    end
    if (issue_ok) begin
      pend_next[IssueRd] = 1'b1;
    end
    pend_next[ZERO_IDX] = 1'b0;
  end

  always_comb begin
    cnt_next = PendCnt;
    if (set_new && !clr_real) begin
      cnt_next = PendCnt + (ADDR_W+1)'(1);
    end else if (clr_real && !set_new) begin
      cnt_next = PendCnt - (ADDR_W+1)'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (!ResetL) begin
      pend    <= '0;
      PendCnt <= '0;
    end else begin
      pend    <= pend_next;
      PendCnt <= cnt_next;
    end
  end

endmodule

// File: rtl/reg_file_scoreboard_top.sv
// reg_file_scoreboard_top
// Parametrised register file with NUM_RD combinational read ports, a
// synchronous whole-array clear, a hardwired-zero register and a per-register
// pending scoreboard for RAW hazard detection.
// Optional feature macro: REGFILE_BYPASS_EN. When defined, a writeback in the
// current cycle is forwarded to any read port addressing the same register,
// and that port's Busy is suppressed in the same cycle.
// Ports:
//   Clk      - clock, state updates on rising edge
//   ResetL   - synchronous active-low reset (array, pend and PendCnt to 0)
//   RA       - packed read addresses, port k = RA[k*ADDR_W +: ADDR_W]
//   BusR     - packed read data, port k = BusR[k*DATA_W +: DATA_W]
//   Busy     - port k's register has a pending write
//   RW       - writeback register index
//   BusW     - writeback data
//   RegWr    - writeback enable
//   IssueVal - an instruction with a destination issues this cycle
//   IssueRd  - destination register of the issuing instruction
//   PendCnt  - number of registers currently pending
module reg_file_scoreboard_top
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = ZERO_REG_DEF
) (
  input  logic                     Clk,
  input  logic                     ResetL,
  input  logic [NUM_RD*ADDR_W-1:0] RA,
  output logic [NUM_RD*DATA_W-1:0] BusR,
  output logic [NUM_RD-1:0]        Busy,
  input  logic [ADDR_W-1:0]        RW,
  input  logic [DATA_W-1:0]        BusW,
  input  logic                     RegWr,
  input  logic                     IssueVal,
  input  logic [ADDR_W-1:0]        IssueRd,
  output logic [ADDR_W:0]          PendCnt
);

  localparam int                DEPTH    = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pend;

  // Writes in a reset cycle are discarded; the zero register is never written.
  always_ff @(posedge Clk) begin
    if (!ResetL) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (RegWr && (RW != ZERO_IDX)) begin
      regs[RW] <= BusW;
    end
  end

  reg_file_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .Clk      (Clk),
    .ResetL   (ResetL),
    .IssueVal (IssueVal),
    .IssueRd  (IssueRd),
    .RegWr    (RegWr),
    .RW       (RW),
    .pend     (pend),
    .PendCnt  (PendCnt)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit;

    assign ra = RA[k*ADDR_W +: ADDR_W];

`ifdef REGFILE_BYPASS_EN
    // A same-cycle issue to RW does not block forwarding; it only affects
    // pend from the next cycle on.
    assign hit = RegWr && (RW != ZERO_IDX) && (ra == RW);
`else
    assign hit = 1'b0;
`endif

    assign BusR[k*DATA_W +: DATA_W] = (ra == ZERO_IDX) ? '0 :
                                      hit              ? BusW :
                                                         regs[ra];
    // pend[ZERO_REG] is held at 0, so the zero register never reads Busy.
    assign Busy[k] = pend[ra] & ~hit;
  end

endmodule

// File: tb/tb_reg_file_scoreboard_top.sv
// tb_reg_file_scoreboard_top
// Directed test of reg_file_scoreboard_top with hand-computed expectations.
// Works with or without REGFILE_BYPASS_EN; bypass-dependent expectations are
// selected by the same macro.
module tb_reg_file_scoreboard_top;
  import reg_file_pkg::*;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;

  logic                     Clk;
  logic                     ResetL;
  logic [NUM_RD*ADDR_W-1:0] RA;
  logic [NUM_RD*DATA_W-1:0] BusR;
  logic [NUM_RD-1:0]        Busy;
  logic [ADDR_W-1:0]        RW;
  logic [DATA_W-1:0]        BusW;
  logic                     RegWr;
  logic                     IssueVal;
  logic [ADDR_W-1:0]        IssueRd;
  logic [ADDR_W:0]          PendCnt;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_word;

  reg_file_scoreboard_top #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (31)
  ) dut (
    .Clk      (Clk),
    .ResetL   (ResetL),
    .RA       (RA),
    .BusR     (BusR),
    .Busy     (Busy),
    .RW       (RW),
    .BusW     (BusW),
    .RegWr    (RegWr),
    .IssueVal (IssueVal),
    .IssueRd  (IssueRd),
    .PendCnt  (PendCnt)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Advance one rising edge, then settle 1 time unit away from the edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    RegWr    = 1'b0;
    IssueVal = 1'b0;
    RW       = '0;
    BusW     = '0;
    IssueRd  = '0;
  endtask

  task automatic set_ra(input reg_idx_t a0, input reg_idx_t a1);
    RA = {a1, a0};
    #1;
  endtask

  task automatic drive_write(input reg_idx_t r, input reg_word_t d);
    RegWr = 1'b1;
    RW    = r;
    BusW  = d;
  endtask

  task automatic drive_issue(input reg_idx_t r);
    IssueVal = 1'b1;
    IssueRd  = r;
  endtask

  task automatic write_reg(input reg_idx_t r, input reg_word_t d);
    drive_write(r, d);
    tick();
    idle();
  endtask

  task automatic issue_reg(input reg_idx_t r);
    drive_issue(r);
    tick();
    idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    ResetL = 1'b0;
    RA     = '0;
    idle();
    tick();
    tick();
    ResetL = 1'b1;

    // Reset values
    set_ra(5'd0, 5'd1);
    check("rst_busr0", BusR[63:0], 64'h0);
    check("rst_busr1", BusR[127:64], 64'h0);
    check("rst_busy", {62'h0, Busy}, 64'h0);
    check("rst_pendcnt", {58'h0, PendCnt}, 64'h0);

    // Reset discards stored data and in-flight write/issue
    write_reg(5'd3, 64'hDEAD);
    set_ra(5'd3, 5'd4);
    check("pre_rst_r3", BusR[63:0], 64'hDEAD);
    ResetL = 1'b0;
    drive_write(5'd4, 64'h55);
    drive_issue(5'd6);
    tick();
    ResetL = 1'b1;
    idle();
    set_ra(5'd3, 5'd4);
    check("rst_r3", BusR[63:0], 64'h0);
    check("rst_r4_dropped", BusR[127:64], 64'h0);
    set_ra(5'd6, 5'd3);
    check("rst_issue_dropped", {62'h0, Busy}, 64'h0);
    check("rst_pendcnt2", {58'h0, PendCnt}, 64'h0);

    // Zero register
    write_reg(5'd31, 64'h12345678);
    set_ra(5'd31, 5'd31);
    check("zero_read", BusR[63:0], 64'h0);
    issue_reg(5'd31);
    set_ra(5'd31, 5'd31);
    check("zero_busy", {62'h0, Busy}, 64'h0);
    check("zero_pendcnt", {58'h0, PendCnt}, 64'h0);

    // Fill 0..30 and read back pairs
    for (int i = 0; i < 31; i++) begin
      write_reg(5'(i), 64'h100 + 64'(i));
      exp_q.push_back(64'h100 + 64'(i));
    end
    for (int i = 0; i < 30; i++) begin
      set_ra(5'(i), 5'(i + 1));
      exp_word = exp_q.pop_front();
      check("fill_port0", BusR[63:0], exp_word);
      check("fill_port1", BusR[127:64], exp_q[0]);
    end
    exp_word = exp_q.pop_front();
    set_ra(5'd30, 5'd0);
    check("fill_r30", BusR[63:0], exp_word);

    // Scoreboard set then clear
    issue_reg(5'd5);
    set_ra(5'd5, 5'd4);
    check("sb_busy5", {62'h0, Busy}, 64'h1);
    check("sb_cnt1", {58'h0, PendCnt}, 64'h1);
    write_reg(5'd5, 64'hABCD);
    set_ra(5'd5, 5'd4);
    check("sb_busy5_clr", {62'h0, Busy}, 64'h0);
    check("sb_cnt0", {58'h0, PendCnt}, 64'h0);
    check("sb_data5", BusR[63:0], 64'hABCD);

    // Same-cycle issue and write on pending reg 7: set wins, data written
    issue_reg(5'd7);
    drive_issue(5'd7);
    drive_write(5'd7, 64'h7777);
    tick();
    idle();
    set_ra(5'd7, 5'd0);
    check("same_busy7", {62'h0, Busy}, 64'h1);
    check("same_cnt", {58'h0, PendCnt}, 64'h1);
    check("same_data7", BusR[63:0], 64'h7777);

    // Re-issue of a pending register
    issue_reg(5'd7);
    check("reissue_cnt", {58'h0, PendCnt}, 64'h1);

    // Issue 8 while writing 7: one set, one clear, net zero
    drive_issue(5'd8);
    drive_write(5'd7, 64'h7070);
    tick();
    idle();
    set_ra(5'd7, 5'd8);
    check("swap_busy", {62'h0, Busy}, 64'h2);
    check("swap_cnt", {58'h0, PendCnt}, 64'h1);

    // Write to a non-pending register leaves the count alone
    write_reg(5'd9, 64'h99);
    check("nopend_cnt", {58'h0, PendCnt}, 64'h1);
    write_reg(5'd8, 64'h88);
    check("clr8_cnt", {58'h0, PendCnt}, 64'h0);

    // Write forwarding on reg 12 (holds 0x10c from the fill)
    set_ra(5'd12, 5'd0);
    drive_write(5'd12, 64'h1010);
    #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_pre", BusR[63:0], 64'h1010);
`else
    check("byp_pre", BusR[63:0], 64'h10C);
`endif
    tick();
    idle();
    set_ra(5'd12, 5'd0);
    check("byp_post", BusR[63:0], 64'h1010);

    // Busy during a write to pending reg 12 with a same-cycle re-issue
    issue_reg(5'd12);
    drive_issue(5'd12);
    drive_write(5'd12, 64'h2020);
    set_ra(5'd12, 5'd0);
`ifdef REGFILE_BYPASS_EN
    check("byp_busy_pre", {62'h0, Busy}, 64'h0);
    check("byp_data_pre", BusR[63:0], 64'h2020);
`else
    check("byp_busy_pre", {62'h0, Busy}, 64'h1);
    check("byp_data_pre", BusR[63:0], 64'h1010);
`endif
    tick();
    idle();
    set_ra(5'd12, 5'd0);
    check("byp_busy_post", {62'h0, Busy}, 64'h1);
    check("byp_cnt_post", {58'h0, PendCnt}, 64'h1);

    // Reset mid-operation discards pending state and data
    ResetL = 1'b0;
    tick();
    ResetL = 1'b1;
    set_ra(5'd12, 5'd7);
    check("midrst_cnt", {58'h0, PendCnt}, 64'h0);
    check("midrst_busy", {62'h0, Busy}, 64'h0);
    check("midrst_r12", BusR[63:0], 64'h0);
    check("midrst_r7", BusR[127:64], 64'h0);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
